pipe_scroller: RTL
==================

# pipe_scroller

Scrolls the five pipe/coin obstacle slots across the 330-pixel playfield, one step per video frame. Supplies the slot edge coordinates that the pixel display selector rasterises: pipe X/Y edges, coin boxes, a `shift_Coin` reveal strobe and a score strobe. Each recycled slot gets a pseudo-random gap height.

## Interface
- `LEFT`, 155: first playfield column.
- `BG_W`, 330: playfield width; last column is `LEFT+BG_W-1` = 484.
- `PIPE_W`, 52: pipe width in px.
- `GAP_H`, 120: vertical gap, `Y_Bottom − Y_Top`.
- `GAP_MIN`, 80: minimum `Y_Top`.
- `SPACING`, 132: slot pitch; ring span `SPAN = 5*SPACING` = 660.
- `SPEED`, 2: px per frame; requires `1 ≤ SPEED < SPACING`.

Ports:
- `clk_vga` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `frame_tick` in 1: one-cycle pulse per frame.
- `run` in 1: game active.
- `q_Initial` in 1: synchronous game restart.
- `bird_x_l` in 10: bird left edge.
- `x_edge_l`, `x_edge_r` out 50: slot i occupies bits [10i+9:10i]; clipped pipe columns.
- `y_edge_top`, `y_edge_bottom` out 50: gap bounds per slot.
- `x_coin_l`, `x_coin_r`, `y_coin` out 50: coin box per slot.
- `shift_Coin` out 1: one-cycle pulse per slot recycle.
- `pass_pulse` out 1: one-cycle pulse when a pipe clears the bird.

## Operation
- **Per-slot state:**
  - 11-bit ring position `p[i]`.
  - 8-bit gap offset `g[i]`.
- **Reset / restart:** `rst_n=0` or `q_Initial=1` sets:
  - `p[i] = 382 + 132*i`, giving 382, 514, 646, 778, 910 (all off-screen right).
  - `g[i] = 80`.
  - LFSR = 16'hACE1.
  - `shift_Coin = pass_pulse = 0`.
- **Advance:** on `frame_tick & run`, every slot steps:
  - If `p ≤ SPEED`: wrap to `p − SPEED + SPAN`, load `g = lfsr[7:0]`, then step the LFSR.
  - Otherwise: `p ← p − SPEED`.
  - `run=0` ignores ticks; state holds.
- **LFSR:** 16-bit Fibonacci, taps 16, 14, 13, 11. It steps once per wrap. Spacing guarantees at most one wrap per tick.
- **Screen mapping (combinational from state):**
  - Raw left `L = p + LEFT − PIPE_W`; raw right `R = L + PIPE_W − 1`.
  - Visible iff `1 ≤ p ≤ 381`.
  - Visible slot: `x_edge_l = max(L, LEFT)`, `x_edge_r = min(R, 484)`.
  - Hidden slot: `x_edge_l = 1023`, `x_edge_r = 0`, so no pixel matches.
  - `y_edge_top = GAP_MIN + g`; `y_edge_bottom = y_edge_top + GAP_H`.
  - Coin: `x_coin_l = L+16`, `x_coin_r = L+35`, clipped/hidden like the pipe. `y_coin = y_edge_top + 50`.
- **`shift_Coin`:** high the cycle after any slot wraps.
- **`pass_pulse`:** high the cycle after a tick in which any slot's raw right edge goes from `≥ bird_x_l` to `< bird_x_l`. Evaluated only when the slot was visible before the step.
- **Arithmetic:** 11-bit internally; outputs truncated to 10 bits (all in range).

## Timing
- The state update happens on the `clk_vga` edge that samples `frame_tick`. Geometry outputs are valid immediately after that edge (one-cycle latency, no pipeline).
- `shift_Coin` and `pass_pulse` are registered single-cycle pulses, aligned with the updated geometry.
- Simultaneous events, in priority order:
  - `rst_n=0` overrides everything.
  - `q_Initial` overrides `frame_tick`.
  - A wrap and a pass in the same tick each pulse independently.
- Reset mid-scroll: all slots return to the initial ring the next cycle; no pulses are emitted.
- Back-to-back `frame_tick` on consecutive cycles is legal: one step per pulse.

## Structure
- The shared package `flappy_pkg` holds `LEFT`, `BG_W`, `PIPE_W`, `GAP_H`, `GAP_MIN`, `SPACING`, `NPIPE=5` and `LFSR_SEED`. The display selector uses the same values.
- One sub-module: `lfsr16` (step enable, synchronous load of the seed). The rest is a generate loop over slots.

## Test plan
- **Reset:** `rst_n=0` for 1 cycle → all `x_edge_l=1023`, `x_edge_r=0`, `y_edge_top=160`, `y_edge_bottom=280`, `y_coin=210`, pulses 0.
- **First step:** one `frame_tick` with `run=1` → slot 0 `x_edge_l=483`, `x_edge_r=484`; slots 1–4 hidden.
- **First wrap:** 191 ticks → on tick 191 slot 0 goes hidden and `shift_Coin` pulses once, with `y_edge_top=305` and `y_edge_bottom=425` (seed low byte 225).
- **Pass:** `bird_x_l=200`, 169 ticks → `pass_pulse` exactly once, on tick 169 (slot 0 p 46→44).
- **Run gating:** `run=0` with 10 ticks → outputs unchanged, no pulses.
- **Restart priority:** `q_Initial` and `frame_tick` in the same cycle mid-game → reset values, no pulse.

Source files
------------

// File: rtl/flappy_pkg.sv
// flappy_pkg: playfield geometry, slot ring constants and edge clipping helpers
package flappy_pkg;
  localparam int NPIPE = 5;
  localparam logic [10:0] LEFT = 11'd155;
  localparam logic [10:0] BG_W = 11'd330;
  localparam logic [10:0] PIPE_W = 11'd52;
  localparam logic [10:0] GAP_H = 11'd120;
  localparam logic [10:0] GAP_MIN = 11'd80;
  localparam logic [10:0] SPACING = 11'd132;
  localparam logic [10:0] SPEED = 11'd2;
  localparam logic [10:0] SPAN = 11'd660;
  localparam logic [10:0] RIGHT = LEFT + BG_W - 11'd1;
  localparam logic [10:0] VIS_MAX = BG_W + PIPE_W - 11'd1;
  localparam logic [10:0] P0 = VIS_MAX + 11'd1;
  localparam logic [10:0] COIN_L = 11'd16;
  localparam logic [10:0] COIN_R = 11'd35;
  localparam logic [10:0] COIN_DY = 11'd50;
  localparam logic [7:0] G_INIT = 8'd80;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  function automatic logic [9:0] clip_l(input logic [10:0] x);
    return x < LEFT ? LEFT[9:0] : x[9:0];
  endfunction
  function automatic logic [9:0] clip_r(input logic [10:0] x);
    return x > RIGHT ? RIGHT[9:0] : x[9:0];
  endfunction
endpackage

// File: rtl/pipe_scroller_if.sv
// pipe_scroller_if: frame controls in, per-slot obstacle geometry and strobes out
interface pipe_scroller_if;
  logic frame_tick;
  logic run;
  logic q_Initial;
  logic [9:0] bird_x_l;
  logic [49:0] x_edge_l;
  logic [49:0] x_edge_r;
  logic [49:0] y_edge_top;
  logic [49:0] y_edge_bottom;
  logic [49:0] x_coin_l;
  logic [49:0] x_coin_r;
  logic [49:0] y_coin;
  logic shift_Coin;
  logic pass_pulse;
  modport master (
    output frame_tick, run, q_Initial, bird_x_l,
    input x_edge_l, x_edge_r, y_edge_top, y_edge_bottom, x_coin_l, x_coin_r, y_coin, shift_Coin, pass_pulse
  );
  modport slave (
    input frame_tick, run, q_Initial, bird_x_l,
    output x_edge_l, x_edge_r, y_edge_top, y_edge_bottom, x_coin_l, x_coin_r, y_coin, shift_Coin, pass_pulse
  );
endinterface

// File: rtl/pipe_scroller_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) with step enable and seed reload
module lfsr16
  import flappy_pkg::*;
(
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        load,
  input  logic        en,
  output logic [15:0] q
);
  always_ff @(posedge clk_vga)
    if (!rst_n || load) q <= LFSR_SEED;
    else if (en) q <= {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
endmodule

// File: rtl/pipe_scroller.sv
// pipe_scroller: steps five obstacle slots around a 660-px ring once per frame
// and maps each slot onto clipped playfield pipe/coin edges.
module pipe_scroller
  import flappy_pkg::*;
(
  input logic clk_vga,
  input logic rst_n,
  pipe_scroller_if.slave bus
);
  logic [NPIPE-1:0] wrap;
  logic [NPIPE-1:0] pass;
  logic [15:0] lfsr;
  logic [10:0] bird;
  logic step;
  logic clr;
  assign clr = !rst_n || bus.q_Initial;
  assign step = bus.frame_tick && bus.run && !clr;
  assign bird = {1'b0, bus.bird_x_l};
  lfsr16 u_lfsr (
    .clk_vga(clk_vga),
    .rst_n(rst_n),
    .load(bus.q_Initial),
    .en(step && |wrap),
    .q(lfsr)
  );
  for (genvar i = 0; i < NPIPE; i++) begin : g_slot
    logic [10:0] p;
    logic [7:0] g;
    logic [10:0] l;
    logic [10:0] r;
    logic [10:0] yt;
    logic vis;
    assign wrap[i] = p <= SPEED;
    assign vis = |p && p <= VIS_MAX;
    assign l = p + LEFT - PIPE_W;
    assign r = l + PIPE_W - 11'd1;
    assign yt = GAP_MIN + {3'b0, g};
    // a wrapping slot lands off-screen right, so it can never cross the bird
    assign pass[i] = vis && !wrap[i] && r >= bird && r - SPEED < bird;
    assign bus.x_edge_l[10*i +: 10] = vis ? clip_l(l) : 10'd1023;
    assign bus.x_edge_r[10*i +: 10] = vis ? clip_r(r) : 10'd0;
    assign bus.x_coin_l[10*i +: 10] = vis ? clip_l(l + COIN_L) : 10'd1023;
    assign bus.x_coin_r[10*i +: 10] = vis ? clip_r(l + COIN_R) : 10'd0;
    assign bus.y_edge_top[10*i +: 10] = yt[9:0];
    assign bus.y_edge_bottom[10*i +: 10] = 10'(yt + GAP_H);
    assign bus.y_coin[10*i +: 10] = 10'(yt + COIN_DY);
    always_ff @(posedge clk_vga)
      if (clr) begin
        p <= P0 + SPACING * 11'(i);
        g <= G_INIT;
      end else if (step) begin
        p <= wrap[i] ? p - SPEED + SPAN : p - SPEED;
        if (wrap[i]) g <= lfsr[7:0];
      end
  end
  always_ff @(posedge clk_vga)
    if (clr) begin
      bus.shift_Coin <= 1'b0;
      bus.pass_pulse <= 1'b0;
    end else begin
      bus.shift_Coin <= step && |wrap;
      bus.pass_pulse <= step && |pass;
    end
endmodule
